// File: rtl/lap_ctl.sv
// lap_ctl: stopwatch control FSM with a lap buffer and lap recall.
// Sequences the shared time counter through IDLE, COUNTING, SPLIT and
// PAUSED, captures time_in into a LAPS-deep lap buffer and lets the user
// page through stored laps while paused.
// Build option: define LAP_WRAP_EN to make the lap buffer circular
// (a capture while full overwrites the oldest slot). Without it, a capture
// while full is dropped and the display shows the last slot.
module lap_ctl #(
  parameter int CNT_W = 16,
  parameter int LAPS  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       trig,
  input  logic                       split,
  input  logic                       next,
  input  logic [CNT_W-1:0]           time_in,
  output logic                       init_regs,
  output logic                       count_enabled,
  output logic                       disp_sel,
  output logic [CNT_W-1:0]           disp_time,
  output logic [$clog2(LAPS+1)-1:0]  lap_count,
  output logic                       lap_full
);

  localparam int CW = $clog2(LAPS+1);
  localparam int PW = $clog2(LAPS);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_COUNT  = 2'd1;
  localparam logic [1:0] S_SPLIT  = 2'd2;
  localparam logic [1:0] S_PAUSED = 2'd3;

  localparam logic [CW-1:0] LAPS_C    = CW'(LAPS);
  localparam logic [PW-1:0] LAST_SLOT = PW'(LAPS-1);

  logic [1:0]       state_q, state_d;
  logic             trig_q, split_q, next_q;
  logic [CNT_W-1:0] lap_mem_q [LAPS];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_idx_q, rd_idx_d;
  logic [CW-1:0]    lap_count_q, lap_count_d;
  logic             first_q, first_d;
  logic             disp_sel_q, disp_sel_d;
  logic [CNT_W-1:0] disp_time_q, disp_time_d;

  logic             trig_ev, split_ev, next_ev;
  logic             full;
  logic             wr_en;
  logic [PW-1:0]    wr_ptr_inc;
  logic [CW-1:0]    rd_idx_inc;
  logic [LAPS-1:0]  slot_we;

  // Rising-edge events: a held button yields exactly one event.
  assign trig_ev  = trig  & ~trig_q;
  assign split_ev = split & ~split_q;
  assign next_ev  = next  & ~next_q;

  assign full       = (lap_count_q == LAPS_C);
  assign wr_ptr_inc = (wr_ptr_q == LAST_SLOT) ? '0 : wr_ptr_q + 1'b1;
  assign rd_idx_inc = CW'(rd_idx_q) + CW'(1);

  // Per-slot write enables for the lap buffer.
  for (genvar gi = 0; gi < LAPS; gi++) begin : g_slot_we
    assign slot_we[gi] = wr_en && (wr_ptr_q == PW'(gi));
  end

  // Next-state logic: FSM transitions, lap capture and recall stepping.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_idx_d    = rd_idx_q;
    lap_count_d = lap_count_q;
    first_d     = first_q;
    disp_sel_d  = disp_sel_q;
    wr_en       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (trig_ev) state_d = S_COUNT;
      end
      S_COUNT: begin
        if (trig_ev) begin
          state_d    = S_PAUSED;
          first_d    = 1'b1;
          disp_sel_d = 1'b0;
        end else if (split_ev) begin
          state_d    = S_SPLIT;
          disp_sel_d = 1'b1;
          if (!full) begin
            wr_en       = 1'b1;
            wr_ptr_d    = wr_ptr_inc;
            lap_count_d = lap_count_q + 1'b1;
            rd_idx_d    = wr_ptr_q;
          end else begin
`ifdef LAP_WRAP_EN
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_inc;
            rd_idx_d = wr_ptr_q;
`else
            rd_idx_d = LAST_SLOT;
`endif
          end
        end
      end
      S_SPLIT: begin
        if (trig_ev) begin
          state_d    = S_PAUSED;
          first_d    = 1'b1;
          disp_sel_d = 1'b0;
        end else if (split_ev) begin
          state_d    = S_COUNT;
          disp_sel_d = 1'b0;
        end
      end
      S_PAUSED: begin
        if (trig_ev) begin
          state_d    = S_COUNT;
          disp_sel_d = 1'b0;
        end else if (split_ev) begin
          // Clearing only forgets the laps; memory contents stay.
          state_d     = S_IDLE;
          disp_sel_d  = 1'b0;
          lap_count_d = '0;
          wr_ptr_d    = '0;
          rd_idx_d    = '0;
        end else if (next_ev && (lap_count_q != '0)) begin
          disp_sel_d = 1'b1;
          first_d    = 1'b0;
          if (first_q || (rd_idx_inc >= lap_count_q)) rd_idx_d = '0;
          else                                        rd_idx_d = rd_idx_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Forward the value being written so disp_time shows a capture at once.
    if (wr_en && (wr_ptr_q == rd_idx_d)) disp_time_d = time_in;
    else                                 disp_time_d = lap_mem_q[rd_idx_d];
  end

  // Control and display registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      trig_q      <= 1'b0;
      split_q     <= 1'b0;
      next_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_idx_q    <= '0;
      lap_count_q <= '0;
      first_q     <= 1'b0;
      disp_sel_q  <= 1'b0;
      disp_time_q <= '0;
    end else begin
      state_q     <= state_d;
      trig_q      <= trig;
      split_q     <= split;
      next_q      <= next;
      wr_ptr_q    <= wr_ptr_d;
      rd_idx_q    <= rd_idx_d;
      lap_count_q <= lap_count_d;
      first_q     <= first_d;
      disp_sel_q  <= disp_sel_d;
      disp_time_q <= disp_time_d;
    end
  end

  // Lap buffer storage; every slot resets to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LAPS; i++) lap_mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < LAPS; i++) begin
        if (slot_we[i]) lap_mem_q[i] <= time_in;
      end
    end
  end

  assign init_regs     = (state_q == S_IDLE);
  assign count_enabled = (state_q == S_COUNT) || (state_q == S_SPLIT);
  assign disp_sel      = disp_sel_q;
  assign disp_time     = disp_time_q;
  assign lap_count     = lap_count_q;
  assign lap_full      = full;

endmodule

// File: tb/tb_lap_ctl.sv
// Testbench for lap_ctl: directed scenarios with literal expectations plus
// randomized button traffic, all compared every cycle against a behavioural
// model of the stopwatch rules.
module tb_lap_ctl;

  localparam int CNT_W = 16;
  localparam int LAPS  = 4;
  localparam int CW    = $clog2(LAPS+1);

  localparam int M_IDLE = 0;
  localparam int M_CNT  = 1;
  localparam int M_SPL  = 2;
  localparam int M_PAU  = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             trig = 1'b0;
  logic             split = 1'b0;
  logic             next = 1'b0;
  logic [CNT_W-1:0] time_in = '0;
  logic             init_regs;
  logic             count_enabled;
  logic             disp_sel;
  logic [CNT_W-1:0] disp_time;
  logic [CW-1:0]    lap_count;
  logic             lap_full;

  int total = 0;
  int bad   = 0;

  lap_ctl #(.CNT_W(CNT_W), .LAPS(LAPS)) dut (
    .clk          (clk),
    .reset        (reset),
    .trig         (trig),
    .split        (split),
    .next         (next),
    .time_in      (time_in),
    .init_regs    (init_regs),
    .count_enabled(count_enabled),
    .disp_sel     (disp_sel),
    .disp_time    (disp_time),
    .lap_count    (lap_count),
    .lap_full     (lap_full)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int               m_mode;
  int               m_total;   // captures since clear (grows past LAPS only when wrapping)
  int               m_rd;
  bit               m_first;
  bit               m_sel;
  bit               pt, ps, pn;
  logic [CNT_W-1:0] m_mem [LAPS];

  function automatic int m_count();
    return (m_total < LAPS) ? m_total : LAPS;
  endfunction

  task automatic m_reset();
    m_mode = M_IDLE; m_total = 0; m_rd = 0; m_first = 0; m_sel = 0;
    pt = 0; ps = 0; pn = 0;
    for (int i = 0; i < LAPS; i++) m_mem[i] = '0;
  endtask

  task automatic m_capture(input logic [CNT_W-1:0] v);
    int slot;
`ifdef LAP_WRAP_EN
    slot = m_total % LAPS;
    m_mem[slot] = v;
    m_rd = slot;
    m_total++;
`else
    if (m_total < LAPS) begin
      slot = m_total;
      m_mem[slot] = v;
      m_rd = slot;
      m_total++;
    end else begin
      m_rd = LAPS - 1;
    end
`endif
  endtask

  task automatic m_step();
    bit et, es, en;
    et = trig && !pt; es = split && !ps; en = next && !pn;
    pt = trig; ps = split; pn = next;
    case (m_mode)
      M_IDLE: if (et) m_mode = M_CNT;
      M_CNT: begin
        if (et) begin m_mode = M_PAU; m_first = 1; m_sel = 0; end
        else if (es) begin m_capture(time_in); m_mode = M_SPL; m_sel = 1; end
      end
      M_SPL: begin
        if (et) begin m_mode = M_PAU; m_first = 1; m_sel = 0; end
        else if (es) begin m_mode = M_CNT; m_sel = 0; end
      end
      default: begin
        if (et) begin m_mode = M_CNT; m_sel = 0; end
        else if (es) begin m_mode = M_IDLE; m_sel = 0; m_total = 0; m_rd = 0; end
        else if (en && m_count() > 0) begin
          m_sel = 1;
          m_rd = m_first ? 0 : (m_rd + 1) % m_count();
          m_first = 0;
        end
      end
    endcase
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) m_reset();
      else m_step();
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      check("cyc_init_regs", 32'(init_regs), 32'(m_mode == M_IDLE));
      check("cyc_count_en", 32'(count_enabled), 32'(m_mode == M_CNT || m_mode == M_SPL));
      check("cyc_disp_sel", 32'(disp_sel), 32'(m_sel));
      check("cyc_disp_time", 32'(disp_time), 32'(m_mem[m_rd]));
      check("cyc_lap_count", 32'(lap_count), 32'(m_count()));
      check("cyc_lap_full", 32'(lap_full), 32'(m_count() == LAPS));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input logic t, input logic s, input logic n, input logic [CNT_W-1:0] tv);
    trig = t; split = s; next = n; time_in = tv;
    @(posedge clk);
    #2;
  endtask

  logic [CNT_W-1:0] exp_slots [4];
  logic [CNT_W-1:0] exp_recall [3];

  initial begin
    exp_recall[0] = 16'd7; exp_recall[1] = 16'd9; exp_recall[2] = 16'd7;
`ifdef LAP_WRAP_EN
    exp_slots[0] = 16'd50;
`else
    exp_slots[0] = 16'd10;
`endif
    exp_slots[1] = 16'd20; exp_slots[2] = 16'd30; exp_slots[3] = 16'd40;

    #3;
    check("rst_init_regs", 32'(init_regs), 32'd1);
    check("rst_count_en", 32'(count_enabled), 32'd0);
    check("rst_disp_time", 32'(disp_time), 32'd0);
    check("rst_lap_full", 32'(lap_full), 32'd0);
    #9;
    reset = 1'b0;

    // idle for three cycles
    repeat (3) tick(0, 0, 0, 0);
    check("idle_init_regs", 32'(init_regs), 32'd1);
    check("idle_disp_sel", 32'(disp_sel), 32'd0);
    check("idle_lap_count", 32'(lap_count), 32'd0);

    // trig pulse starts counting
    tick(1, 0, 0, 0);
    check("start_init_regs", 32'(init_regs), 32'd0);
    check("start_count_en", 32'(count_enabled), 32'd1);
    tick(0, 0, 0, 0);

    // split capture of 0x0123
    tick(0, 1, 0, 16'h0123);
    check("split_disp_sel", 32'(disp_sel), 32'd1);
    check("split_disp_time", 32'(disp_time), 32'h0123);
    check("split_lap_count", 32'(lap_count), 32'd1);
    check("split_count_en", 32'(count_enabled), 32'd1);
    tick(0, 0, 0, 0);
    tick(0, 1, 0, 0);
    check("unsplit_disp_sel", 32'(disp_sel), 32'd0);
    check("unsplit_count_en", 32'(count_enabled), 32'd1);
    tick(0, 0, 0, 0);

    // trig held 5 cycles: exactly one pause
    for (int i = 0; i < 5; i++) begin
      tick(1, 0, 0, 0);
      check("hold_count_en", 32'(count_enabled), 32'd0);
      check("hold_init_regs", 32'(init_regs), 32'd0);
    end
    tick(0, 0, 0, 0);
    tick(0, 1, 0, 0);
    check("clear_lap_count", 32'(lap_count), 32'd0);
    tick(0, 0, 0, 0);

    // five captures into a four-deep buffer
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick(0, 1, 0, CNT_W'((i + 1) * 10));
      if (i == 4) begin
        check("fill_lap_count", 32'(lap_count), 32'd4);
        check("fill_lap_full", 32'(lap_full), 32'd1);
`ifdef LAP_WRAP_EN
        check("fill_disp_time", 32'(disp_time), 32'd50);
`else
        check("fill_disp_time", 32'(disp_time), 32'd40);
`endif
      end
      tick(0, 0, 0, 0);
      tick(0, 1, 0, 0);
      tick(0, 0, 0, 0);
    end
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      tick(0, 0, 1, 0);
      check("slot_recall", 32'(disp_time), 32'(exp_slots[k]));
      tick(0, 0, 0, 0);
    end
    tick(0, 1, 0, 0);
    tick(0, 0, 0, 0);

    // laps 7 and 9, recall 7, 9, 7, then clear
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 1, 0, 16'd7); tick(0, 0, 0, 0); tick(0, 1, 0, 0); tick(0, 0, 0, 0);
    tick(0, 1, 0, 16'd9); tick(0, 0, 0, 0); tick(0, 1, 0, 0); tick(0, 0, 0, 0);
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      tick(0, 0, 1, 0);
      check("recall_disp_time", 32'(disp_time), 32'(exp_recall[k]));
      check("recall_disp_sel", 32'(disp_sel), 32'd1);
      tick(0, 0, 0, 0);
    end
    tick(0, 1, 0, 0);
    check("clr_init_regs", 32'(init_regs), 32'd1);
    check("clr_lap_count", 32'(lap_count), 32'd0);
    check("clr_disp_sel", 32'(disp_sel), 32'd0);
    tick(0, 0, 0, 0);

    // trig and split together: pause wins, no capture
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    tick(1, 1, 0, 16'h0055);
    check("prio_count_en", 32'(count_enabled), 32'd0);
    check("prio_init_regs", 32'(init_regs), 32'd0);
    check("prio_lap_count", 32'(lap_count), 32'd0);
    tick(0, 0, 0, 0);
    tick(0, 0, 1, 0);
    check("empty_next_sel", 32'(disp_sel), 32'd0);
    tick(0, 0, 0, 0);

    // asynchronous reset in the middle of SPLIT
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 1, 0, 16'hBEEF);
    check("pre_rst_disp_time", 32'(disp_time), 32'hBEEF);
    split = 1'b0;
    reset = 1'b1;
    #1;
    check("arst_init_regs", 32'(init_regs), 32'd1);
    check("arst_count_en", 32'(count_enabled), 32'd0);
    check("arst_disp_sel", 32'(disp_sel), 32'd0);
    check("arst_disp_time", 32'(disp_time), 32'd0);
    check("arst_lap_count", 32'(lap_count), 32'd0);
    check("arst_lap_full", 32'(lap_full), 32'd0);
    @(posedge clk);
    #2;
    reset = 1'b0;

    // randomized button traffic against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 999) < 3) begin
        reset = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
      end else begin
        tick(1'($urandom_range(0, 99) < 20),
             1'($urandom_range(0, 99) < 40),
             1'($urandom_range(0, 99) < 40),
             CNT_W'($urandom));
      end
    end
    tick(0, 0, 0, 0);
    @(negedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lap_ctl.md
# lap_ctl

Parametrised stopwatch control FSM with lap capture: the next-generation stopwatch controller. It sequences the shared time counter through idle, counting, split-display and paused states, stores up to LAPS captured time values in an internal lap buffer, and lets the user page through stored laps while paused. It sits between the button inputs and the counter/display datapath. It drives the counter's init/enable controls and selects whether the display shows the live count or a stored lap.

## Interface
- CNT_W, 16: width of time_in and disp_time.
- LAPS, 4: lap buffer depth, ≥2; lap_count width is $clog2(LAPS+1), pointers $clog2(LAPS).
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- trig  input  1  start/pause button, level; internally edge-detected.
- split  input  1  split/clear button, level; internally edge-detected.
- next  input  1  lap-recall step button, level; internally edge-detected.
- time_in  input  CNT_W  current counter value, sampled on capture.
- init_regs  output  1  counter clear request.
- count_enabled  output  1  counter run enable.
- disp_sel  output  1  0 = display live counter, 1 = display disp_time.
- disp_time  output  CNT_W  selected stored lap value.
- lap_count  output  $clog2(LAPS+1)  number of valid laps.
- lap_full  output  1  lap_count == LAPS.

## Operation
- Edge detect: per button, a register x_q (reset 0); an event is x & ~x_q. A button held high produces exactly one event. A button already high when reset releases produces an event on the first clock.
- States: IDLE, COUNTING, SPLIT, PAUSED. Decoded outputs: IDLE init_regs=1, count_enabled=0; COUNTING 0/1; SPLIT 0/1; PAUSED 0/0.
- IDLE: trig → COUNTING. split and next are ignored.
- COUNTING: trig → PAUSED. split → capture time_in, then SPLIT. next is ignored.
- SPLIT: the counter keeps running. disp_sel=1 and disp_time shows the last captured slot.
  - split → COUNTING.
  - trig → PAUSED.
- PAUSED: disp_sel=0 on entry.
  - trig → COUNTING.
  - split → IDLE, which clears lap_count, the write pointer, rd_idx and lap_full. Memory contents are not cleared.
  - next with lap_count>0: sets disp_sel=1 and advances rd_idx. The first next after entry selects slot 0. Each further next selects (rd_idx+1) mod lap_count.
  - next with lap_count=0 is ignored.
- Capture:
  - Not full: time_in is written to slot wr_ptr, wr_ptr increments, lap_count increments, and rd_idx is set to the written slot.
  - Full: behaviour depends on LAP_WRAP_EN (see Configuration).
- Priority when events coincide in one cycle: trig > split > next. Lower-priority events in that cycle are discarded, including the capture.
- Leaving SPLIT or PAUSED to any state other than the same state clears disp_sel to 0.

## Timing
- Reset values: state=IDLE, init_regs=1, count_enabled=0, disp_sel=0, disp_time=0, lap_count=0, lap_full=0, all pointers 0, all lap slots 0.
- Reset is asynchronous. Outputs take their reset values immediately, without a clock, including mid-SPLIT or mid-capture.
- All outputs are registered or decoded from registers. There is no combinational path from any input to any output.
- Latency: a button rising before edge N changes state and outputs from edge N. They are visible in the cycle after that edge.
- Capture samples time_in on the same edge as the SPLIT transition. disp_time equals the captured value from that edge on.
- disp_time is always the registered lap_mem[rd_idx].

## Configuration
- LAP_WRAP_EN defined: the buffer is circular. A capture while full overwrites slot wr_ptr (the oldest entry), wr_ptr wraps to 0 after LAPS-1, and lap_count stays at LAPS. Recall order is physical slot order 0..LAPS-1.
- LAP_WRAP_EN undefined: a capture while full is discarded. The state still moves to SPLIT, with rd_idx = LAPS-1 and disp_time showing that slot. lap_full stays 1.

## Test plan
- Reset, then idle for 3 cycles: init_regs=1, count_enabled=0, disp_sel=0, lap_count=0. Assert reset mid-SPLIT between clock edges: all outputs return to reset values before the next edge.
- Pulse trig for 1 cycle: next cycle init_regs=0, count_enabled=1. Then hold trig for 5 cycles: exactly one transition to PAUSED (count_enabled=0).
- In COUNTING, set time_in=16'h0123 and pulse split: SPLIT, disp_sel=1, disp_time=16'h0123, lap_count=1, count_enabled=1. Pulse split again: COUNTING, disp_sel=0.
- With LAPS=4, capture time_in values 10, 20, 30, 40, 50:
  - Without LAP_WRAP_EN: lap_count=4, lap_full=1, slots hold 10/20/30/40, and disp_time=40 after the fifth capture.
  - With LAP_WRAP_EN: slot0=50 and disp_time=50.
- Capture laps 7 and 9, enter PAUSED, pulse next 3 times: disp_time goes 7, 9, 7 with disp_sel=1. Pulse split: IDLE, init_regs=1, lap_count=0, disp_sel=0.
- In COUNTING, raise trig and split in the same cycle: PAUSED, no capture (lap_count unchanged). In PAUSED with lap_count=0, pulse next: disp_sel stays 0.
